sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Upstream neighbour of sobel_calc: converts a raster-order grayscale pixel stream into 3x3 neighbourhood windows d0..d8, plus a window-valid strobe that drives sobel_calc done_i.
- Two line buffers hold the previous two image rows. A 3x3 register array shifts one column per accepted pixel.
- Emits one window per interior centre pixel (no padding), so a frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per row; must be >= 3.
- IMG_HEIGHT, 480, rows per frame; must be >= 3.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- done_i  input  1  pixel valid; data_i is accepted on each rising edge where done_i=1.
- data_i  input  DATA_WIDTH  grayscale pixel, raster order (row-major, top-left first).
- done_o  output  1  window valid, one cycle per window.
- d0_o..d8_o  output  DATA_WIDTH each  window, row-major: d0..d2 top row (oldest), d3..d5 middle, d6..d8 bottom; d8 = newest pixel.
- frame_done_o  output  1  one-cycle pulse coincident with the done_o of the last window of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col_cnt=0, row_cnt=0.
  - All window registers, done_o and frame_done_o = 0.
  - Line-buffer contents are not cleared. Outputs never depend on them before being rewritten, because validity is gated by row_cnt.
  - Mid-frame reset abandons the frame. The next accepted pixel is treated as row 0, col 0.
- Accept cycle (done_i=1), all updates on the same edge:
  - lb0_out = pixel from IMG_WIDTH accepts earlier. lb1_out = pixel from 2*IMG_WIDTH accepts earlier. lb0 is fed by data_i; lb1 is fed by lb0_out.
  - Window shift:
    - d0<=d1, d1<=d2, d2<=lb1_out
    - d3<=d4, d4<=d5, d5<=lb0_out
    - d6<=d7, d7<=d8, d8<=data_i
  - done_o <= (row_cnt>=2 && col_cnt>=2), evaluated on the pre-increment counters of the pixel being accepted.
  - frame_done_o <= (row_cnt==IMG_HEIGHT-1 && col_cnt==IMG_WIDTH-1).
  - Counter update:
    - col_cnt increments; at IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
    - At row IMG_HEIGHT-1, col IMG_WIDTH-1, both counters wrap to 0. The next frame starts immediately and back-to-back frames are supported.
- Latency: 1 cycle. The window containing pixel P as d8 is visible, with done_o=1, right after the edge that accepted P.
- Stall (done_i=0):
  - Counters, line buffers and window registers hold.
  - done_o=0 and frame_done_o=0 on the next edge.
  - d*_o keep their last values.
- Windows at row 0/1 or col 0/1 are internal warm-up states. They shift normally but done_o stays 0. Windows spanning a row wrap are never flagged valid.
- Counter widths: $clog2 of IMG_WIDTH and IMG_HEIGHT. No arithmetic on pixel data; values pass through unchanged.

Decomposition:
- Shared package sobel_pkg:
  - DATA_WIDTH default.
  - Window index constants: centre = d4, newest = d8.
  - Default IMG_WIDTH and IMG_HEIGHT.
- Sub-module line_buffer (params DEPTH=IMG_WIDTH, DATA_WIDTH):
  - Circular RAM with a write pointer and an enable.
  - Read-before-write at the same address gives a DEPTH-accept delay with zero added latency.
  - Instantiated twice (lb0, lb1).

Test Plan:
- IMG_WIDTH=3, IMG_HEIGHT=3, feed 1..9 with done_i=1 continuous -> exactly one done_o pulse, after the edge accepting 9, with d0..d8=1,2,3,4,5,6,7,8,9; frame_done_o pulses on the same cycle. This drives sobel_calc with the same vector as its own bench.
- IMG_WIDTH=4, IMG_HEIGHT=4, feed 1..16 -> exactly 4 done_o pulses, with windows in order:
  - (1,2,3,5,6,7,9,10,11)
  - (2,3,4,6,7,8,10,11,12)
  - (5,6,7,9,10,11,13,14,15)
  - (6,7,8,10,11,12,14,15,16)
  - frame_done_o only with the last window.
- Same 4x4 stream with done_i deasserted for 3 cycles after pixels 6 and 11 -> identical window sequence; done_o=0 during stalls; d*_o held constant during stalls.
- 4x4, two frames back-to-back (1..16 then 101..116) -> second-frame first window is (101,102,103,105,106,107,109,110,111); no valid window spans the frame boundary.
- 4x4, assert rst for 1 cycle after pixel 10, then feed 1..16 -> no done_o before pixel 11 of the new frame; the 4 windows match the 4x4 scenario exactly.
- Reset check: with rst held -> done_o=0, frame_done_o=0, all d*_o=0 regardless of done_i/data_i activity.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel front end: default image geometry, pixel width
// and the indices used to address the 3x3 window.
package sobel_pkg;

  localparam int SOBEL_DATA_WIDTH = 8;
  localparam int SOBEL_IMG_WIDTH  = 640;
  localparam int SOBEL_IMG_HEIGHT = 480;

  // Window stored row-major: 0..2 oldest row, 6..8 newest row.
  localparam int WIN_SIZE   = 9;
  localparam int WIN_CENTRE = 4;
  localparam int WIN_NEWEST = 8;

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// Circular single-row delay line: the value read out on an enabled cycle is the
// one written DEPTH enabled cycles earlier, available in the same cycle.
module line_buffer #(
  parameter int DEPTH      = 640,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;

  // Read-before-write at the same slot yields exactly DEPTH accepts of delay.
  assign rd_data = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into 3x3 windows for sobel_calc, flagging only
// windows whose centre is an interior pixel.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = SOBEL_DATA_WIDTH,
  parameter int IMG_WIDTH  = SOBEL_IMG_WIDTH,
  parameter int IMG_HEIGHT = SOBEL_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] d0_o,
  output logic [DATA_WIDTH-1:0] d1_o,
  output logic [DATA_WIDTH-1:0] d2_o,
  output logic [DATA_WIDTH-1:0] d3_o,
  output logic [DATA_WIDTH-1:0] d4_o,
  output logic [DATA_WIDTH-1:0] d5_o,
  output logic [DATA_WIDTH-1:0] d6_o,
  output logic [DATA_WIDTH-1:0] d7_o,
  output logic [DATA_WIDTH-1:0] d8_o,
  output logic                  frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic [DATA_WIDTH-1:0] lb0_out;
  logic [DATA_WIDTH-1:0] lb1_out;
  logic [DATA_WIDTH-1:0] win [WIN_SIZE];

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) lb0 (
    .clk     (clk),
    .rst     (rst),
    .en      (done_i),
    .wr_data (data_i),
    .rd_data (lb0_out)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) lb1 (
    .clk     (clk),
    .rst     (rst),
    .en      (done_i),
    .wr_data (lb0_out),
    .rd_data (lb1_out)
  );

  // Raster position of the pixel about to be accepted; wraps straight into the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (done_i) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Validity uses the pre-increment position, so warm-up and row-wrap windows are never flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        win[i] <= '0;
      end
    end else begin
      done_o       <= done_i && (row_cnt >= ROW_MIN) && (col_cnt >= COL_MIN);
      frame_done_o <= done_i && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
      if (done_i) begin
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2]          <= lb1_out;
        win[5]          <= lb0_out;
        win[WIN_NEWEST] <= data_i;
      end
    end
  end

  assign d0_o = win[0];
  assign d1_o = win[1];
  assign d2_o = win[2];
  assign d3_o = win[3];
  assign d4_o = win[WIN_CENTRE];
  assign d5_o = win[5];
  assign d6_o = win[6];
  assign d7_o = win[7];
  assign d8_o = win[WIN_NEWEST];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed self-checking bench for sobel_window_gen: a 3x3 and a 4x4 instance
// share one clock; each scenario task checks its own expected windows.
module tb_sobel_window_gen;

  typedef logic [7:0] win_t [9];

  logic       clk = 1'b0;
  logic       rst;
  logic       done3, done4;
  logic [7:0] data3, data4;
  logic       vld3, vld4, frm3, frm4;
  win_t       w3, w4;

  int tests_run    = 0;
  int tests_failed = 0;

  // Hand-derived windows of a 4x4 frame holding pixels 1..16.
  int exp_win [4][9] = '{
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{2, 3, 4, 6, 7, 8, 10, 11, 12},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15},
    '{6, 7, 8, 10, 11, 12, 14, 15, 16}
  };

  always #5 clk = ~clk;

  sobel_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk(clk), .rst(rst), .done_i(done3), .data_i(data3), .done_o(vld3),
    .d0_o(w3[0]), .d1_o(w3[1]), .d2_o(w3[2]), .d3_o(w3[3]), .d4_o(w3[4]),
    .d5_o(w3[5]), .d6_o(w3[6]), .d7_o(w3[7]), .d8_o(w3[8]),
    .frame_done_o(frm3)
  );

  sobel_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .done_i(done4), .data_i(data4), .done_o(vld4),
    .d0_o(w4[0]), .d1_o(w4[1]), .d2_o(w4[2]), .d3_o(w4[3]), .d4_o(w4[4]),
    .d5_o(w4[5]), .d6_o(w4[6]), .d7_o(w4[7]), .d8_o(w4[8]),
    .frame_done_o(frm4)
  );

  function automatic string fmt_win(input win_t w);
    string s;
    s = $sformatf("%0d", w[0]);
    for (int k = 1; k < 9; k++) s = {s, ",", $sformatf("%0d", w[k])};
    return s;
  endfunction

  function automatic win_t exp4(input int n, input int offset);
    win_t e;
    for (int k = 0; k < 9; k++) e[k] = 8'(exp_win[n][k] + offset);
    return e;
  endfunction

  function automatic bit same_win(input win_t a, input win_t b);
    for (int k = 0; k < 9; k++) if (a[k] !== b[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Inputs change #1 after the rising edge; outputs are read at the same point.
  task automatic step3(input logic v, input logic [7:0] px);
    done3 = v; data3 = px;
    @(posedge clk); #1;
    done3 = 1'b0;
  endtask

  task automatic step4(input logic v, input logic [7:0] px);
    done4 = v; data4 = px;
    @(posedge clk); #1;
    done4 = 1'b0;
  endtask

  task automatic test_reset;
    win_t zero = '{default: 8'd0};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      done3 = 1'b1; data3 = 8'($urandom_range(1, 255));
      done4 = 1'b1; data4 = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
      tests_run++;
      if (vld3 !== 1'b0 || frm3 !== 1'b0 || !same_win(w3, zero)) begin
        tests_failed++;
        $display("[TB] FAIL reset3 cycle %0d: done=%b frame=%b win=%s, need 0/0/all zero",
                 i, vld3, frm3, fmt_win(w3));
      end
      tests_run++;
      if (vld4 !== 1'b0 || frm4 !== 1'b0 || !same_win(w4, zero)) begin
        tests_failed++;
        $display("[TB] FAIL reset4 cycle %0d: done=%b frame=%b win=%s, need 0/0/all zero",
                 i, vld4, frm4, fmt_win(w4));
      end
    end
    done3 = 1'b0; done4 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_3x3;
    win_t e;
    int pulses = 0;
    for (int k = 0; k < 9; k++) e[k] = 8'(k + 1);
    for (int p = 1; p <= 9; p++) begin
      step3(1'b1, 8'(p));
      tests_run++;
      if (vld3 !== (p == 9) || frm3 !== (p == 9)) begin
        tests_failed++;
        $display("[TB] FAIL 3x3 flags pixel %0d: done=%b frame=%b, need %b/%b",
                 p, vld3, frm3, p == 9, p == 9);
      end
      if (vld3 === 1'b1) pulses++;
      if (p == 9) begin
        tests_run++;
        if (!same_win(w3, e)) begin
          tests_failed++;
          $display("[TB] FAIL 3x3 window: got %s, need %s", fmt_win(w3), fmt_win(e));
        end
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL 3x3 pulse count: got %0d, need 1", pulses);
    end
  endtask

  task automatic test_4x4;
    int n = 0;
    for (int p = 1; p <= 16; p++) begin
      logic exp_v = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      step4(1'b1, 8'(p));
      tests_run++;
      if (vld4 !== exp_v || frm4 !== (p == 16)) begin
        tests_failed++;
        $display("[TB] FAIL 4x4 flags pixel %0d: done=%b frame=%b, need %b/%b",
                 p, vld4, frm4, exp_v, p == 16);
      end
      if (exp_v) begin
        tests_run++;
        if (!same_win(w4, exp4(n, 0))) begin
          tests_failed++;
          $display("[TB] FAIL 4x4 window %0d: got %s, need %s", n, fmt_win(w4), fmt_win(exp4(n, 0)));
        end
        n++;
      end
    end
  endtask

  task automatic test_stall;
    int n = 0;
    win_t held;
    for (int p = 1; p <= 16; p++) begin
      logic exp_v = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      step4(1'b1, 8'(p));
      tests_run++;
      if (vld4 !== exp_v || frm4 !== (p == 16)) begin
        tests_failed++;
        $display("[TB] FAIL stall flags pixel %0d: done=%b frame=%b, need %b/%b",
                 p, vld4, frm4, exp_v, p == 16);
      end
      if (exp_v) begin
        tests_run++;
        if (!same_win(w4, exp4(n, 0))) begin
          tests_failed++;
          $display("[TB] FAIL stall window %0d: got %s, need %s", n, fmt_win(w4), fmt_win(exp4(n, 0)));
        end
        n++;
      end
      if (p == 6 || p == 11) begin
        held = w4;
        for (int s = 0; s < 3; s++) begin
          step4(1'b0, 8'hEE);
          tests_run++;
          if (vld4 !== 1'b0 || frm4 !== 1'b0 || !same_win(w4, held)) begin
            tests_failed++;
            $display("[TB] FAIL stall hold after %0d cycle %0d: done=%b frame=%b win=%s, need 0/0/%s",
                     p, s, vld4, frm4, fmt_win(w4), fmt_win(held));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    for (int i = 0; i < 32; i++) begin
      int   q     = i % 16;
      int   base  = (i < 16) ? 0 : 100;
      logic exp_v = (q / 4 >= 2) && (q % 4 >= 2);
      step4(1'b1, 8'(base + q + 1));
      tests_run++;
      if (vld4 !== exp_v || frm4 !== (q == 15)) begin
        tests_failed++;
        $display("[TB] FAIL b2b flags input %0d: done=%b frame=%b, need %b/%b",
                 i, vld4, frm4, exp_v, q == 15);
      end
      if (exp_v) begin
        tests_run++;
        if (!same_win(w4, exp4(n % 4, base))) begin
          tests_failed++;
          $display("[TB] FAIL b2b window %0d: got %s, need %s", n, fmt_win(w4), fmt_win(exp4(n % 4, base)));
        end
        n++;
      end
    end
  endtask

  task automatic test_mid_reset;
    int n = 0;
    int first = 0;
    for (int p = 1; p <= 10; p++) begin
      step4(1'b1, 8'(p));
      tests_run++;
      if (vld4 !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL midrst partial pixel %0d: done=%b, need 0", p, vld4);
      end
    end
    rst = 1'b1;
    step4(1'b0, 8'h00);
    rst = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      logic exp_v = ((p - 1) / 4 >= 2) && ((p - 1) % 4 >= 2);
      step4(1'b1, 8'(p));
      tests_run++;
      if (vld4 !== exp_v || frm4 !== (p == 16)) begin
        tests_failed++;
        $display("[TB] FAIL midrst flags pixel %0d: done=%b frame=%b, need %b/%b",
                 p, vld4, frm4, exp_v, p == 16);
      end
      if (vld4 === 1'b1 && first == 0) first = p;
      if (exp_v) begin
        tests_run++;
        if (!same_win(w4, exp4(n, 0))) begin
          tests_failed++;
          $display("[TB] FAIL midrst window %0d: got %s, need %s", n, fmt_win(w4), fmt_win(exp4(n, 0)));
        end
        n++;
      end
    end
    tests_run++;
    if (first != 11) begin
      tests_failed++;
      $display("[TB] FAIL midrst first valid pixel: got %0d, need 11", first);
    end
  endtask

  initial begin
    rst = 1'b1;
    done3 = 1'b0; data3 = 8'd0;
    done4 = 1'b0; data4 = 8'd0;
    @(posedge clk); #1;
    test_reset();
    test_3x3();
    test_4x4();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
